// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: opcodes, FSM states and
// default geometry.
package stack_ctrl_pkg;

  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  typedef enum logic [2:0] {
    ST_SCRUB = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH, one synchronous write port and one
// synchronous read port with one cycle of read latency. The array has no
// reset; the controller scrubs it to zero instead.
module stack_ram
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/stack_controller.sv
// Downward-growing hardware stack. esp counts free entries: DEPTH means
// empty, 0 means full. A push stores to mem[esp-1]; the top of stack is
// mem[esp]. After reset the storage is scrubbed to zero before requests
// are accepted.
module stack_controller
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [31:0]      esp,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err,
  input  logic             clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   ESP_EMPTY  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ESP_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] SCRUB_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] CNT_ONE    = AW'(1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    scrub_cnt_reg, scrub_cnt_next;
  logic [AW:0]      esp_reg, esp_next;
  logic [WIDTH-1:0] push_data_reg, push_data_next;
  logic             is_pop_reg, is_pop_next;
  logic             resp_zero_reg, resp_zero_next;
  logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic             accept;
  logic             overflow_set;
  logic             underflow_set;
  logic [AW:0]      esp_dec;
  logic [WIDTH-1:0] resp_value;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_re;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;

  assign req_ready  = (state_reg == ST_IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign full       = (esp_reg == '0);
  assign empty      = (esp_reg == ESP_EMPTY);
  assign esp        = 32'(esp_reg);
  assign esp_dec    = esp_reg - ESP_ONE;
  // Underflow responses return zero rather than whatever the RAM holds.
  assign resp_value = resp_zero_reg ? '0 : ram_rdata;

  assign rsp_valid     = (state_reg == ST_RESP) && !reset;
  assign rsp_data      = reset ? '0 : (rsp_valid ? resp_value : rsp_data_reg);
  assign overflow_err  = overflow_reg;
  assign underflow_err = underflow_reg;

  // Next-state logic for the FSM, stack pointer and RAM port controls
  always_comb begin
    state_next     = state_reg;
    scrub_cnt_next = scrub_cnt_reg;
    esp_next       = esp_reg;
    push_data_next = push_data_reg;
    is_pop_next    = is_pop_reg;
    resp_zero_next = resp_zero_reg;
    rsp_data_next  = rsp_data_reg;
    overflow_set   = 1'b0;
    underflow_set  = 1'b0;
    ram_we         = 1'b0;
    ram_waddr      = scrub_cnt_reg;
    ram_wdata      = '0;
    ram_re         = 1'b0;
    ram_raddr      = esp_reg[AW-1:0];

    case (state_reg)
      ST_SCRUB: begin
        ram_we         = 1'b1;
        ram_waddr      = scrub_cnt_reg;
        ram_wdata      = '0;
        scrub_cnt_next = scrub_cnt_reg + CNT_ONE;
        if (scrub_cnt_reg == SCRUB_LAST) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_PUSH: begin
              if (full) begin
                overflow_set = 1'b1;
              end else begin
                push_data_next = req_data;
                state_next     = ST_WRITE;
              end
            end
            OP_POP, OP_PEEK: begin
              is_pop_next = (req_op == OP_POP);
              if (empty) begin
                underflow_set  = 1'b1;
                resp_zero_next = 1'b1;
                state_next     = ST_RESP;
              end else begin
                resp_zero_next = 1'b0;
                state_next     = ST_READ;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        ram_we     = 1'b1;
        ram_waddr  = esp_dec[AW-1:0];
        ram_wdata  = push_data_reg;
        esp_next   = esp_dec;
        state_next = ST_IDLE;
      end
      ST_READ: begin
        ram_re     = 1'b1;
        ram_raddr  = esp_reg[AW-1:0];
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_data_next = resp_value;
        if (is_pop_reg && !resp_zero_reg) begin
          esp_next = esp_reg + ESP_ONE;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_SCRUB;
    endcase

    // A set event in the same cycle wins over clear_err.
    overflow_next  = overflow_set  | (overflow_reg  & ~clear_err);
    underflow_next = underflow_set | (underflow_reg & ~clear_err);
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_SCRUB;
      scrub_cnt_reg <= '0;
      esp_reg       <= ESP_EMPTY;
      push_data_reg <= '0;
      is_pop_reg    <= 1'b0;
      resp_zero_reg <= 1'b0;
      rsp_data_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      scrub_cnt_reg <= scrub_cnt_next;
      esp_reg       <= esp_next;
      push_data_reg <= push_data_next;
      is_pop_reg    <= is_pop_next;
      resp_zero_reg <= resp_zero_next;
      rsp_data_reg  <= rsp_data_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // A write pending when reset arrives is dropped.
  stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clock),
    .we    (ram_we && !reset),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_stack_controller.sv
// Scoreboard bench for stack_controller: a queue-based stack model predicts
// responses (pushed into exp_q at acceptance) and architectural state; a
// separate monitor pops exp_q whenever rsp_valid is seen.
module tb_stack_controller;

  localparam int DEPTH = 32;
  localparam int WIDTH = 32;
  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] PEEK = 2'b11;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [WIDTH-1:0] req_data = '0;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [31:0]      esp;
  logic             full;
  logic             empty;
  logic             overflow_err;
  logic             underflow_err;
  logic             clear_err = 1'b0;

  stack_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .esp           (esp),
    .full          (full),
    .empty         (empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .clear_err     (clear_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               lat;
    int               acc;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] stk[$];   // back of the queue is the top of stack
  logic             ovf_m = 1'b0;
  logic             unf_m = 1'b0;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every response strobe must match the oldest expected response
  initial begin
    forever begin
      @(negedge clock);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          $display("rsp: data=%08h latency=%0d", rsp_data, cyc - e.acc);
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    ok = (req_ready === 1'b1);
    if (!ok) chk("ready_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_esp"}, 64'(esp), 64'(DEPTH - stk.size()));
    chk({tag, "_full"}, 64'(full), 64'(stk.size() == DEPTH));
    chk({tag, "_empty"}, 64'(empty), 64'(stk.size() == 0));
    chk({tag, "_ovf"}, 64'(overflow_err), 64'(ovf_m));
    chk({tag, "_unf"}, 64'(underflow_err), 64'(unf_m));
  endtask

  // Issue one request, update the model at acceptance, then check state
  // once the controller is idle again.
  task automatic do_req(input logic [1:0] op, input logic [WIDTH-1:0] d, input logic clr);
    bit ok;
    logic ovf_set, unf_set;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    clear_err = clr;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (op)
      PUSH: if (stk.size() == DEPTH) ovf_set = 1'b1; else stk.push_back(d);
      POP, PEEK: begin
        if (stk.size() == 0) begin
          unf_set = 1'b1;
          exp_q.push_back('{data: '0, lat: 1, acc: cyc});
        end else begin
          exp_q.push_back('{data: stk[$], lat: 2, acc: cyc});
          if (op == POP) void'(stk.pop_back());
        end
      end
      default: ;
    endcase
    ovf_m = ovf_set ? 1'b1 : (clr ? 1'b0 : ovf_m);
    unf_m = unf_set ? 1'b1 : (clr ? 1'b0 : unf_m);
    $display("req: op=%0d data=%08h clr=%0d model_esp=%0d", op, d, clr, DEPTH - stk.size());
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_op    = NOP;
    clear_err = 1'b0;
    wait_ready(ok);
    if (ok) check_state("after_req");
  endtask

  // Count scrub cycles after a reset release made just after a clock edge
  task automatic scrub_check();
    int n = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
    end
    chk("scrub_cycles", 64'(n), 64'(DEPTH));
    $display("scrub: req_ready low for %0d cycles", n);
    check_state("post_scrub");
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clock);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    clear_err = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_esp", 64'(esp), 64'(DEPTH));
    chk("rst_errs", 64'({overflow_err, underflow_err}), 64'd0);
    repeat (cycles - 1) @(posedge clock);
    #1;
    reset = 1'b0;
    stk.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    scrub_check();
  endtask

  initial begin
    bit ok;
    logic [WIDTH-1:0] v;

    // Reset and scrub
    do_reset(3);

    // Push/pop ordering
    do_req(PUSH, 32'hDEADBEEF, 1'b0);
    do_req(PUSH, 32'h12345678, 1'b0);
    do_req(POP, '0, 1'b0);
    do_req(POP, '0, 1'b0);

    // Peek then pop
    do_req(PUSH, 32'hA5A5A5A5, 1'b0);
    do_req(PEEK, '0, 1'b0);
    do_req(POP, '0, 1'b0);

    // Empty boundary, then clear, then clear racing a new underflow
    do_req(POP, '0, 1'b0);
    do_req(NOP, '0, 1'b1);
    do_req(PEEK, '0, 1'b1);
    do_req(NOP, '0, 1'b1);

    // Full boundary
    for (int i = 0; i < DEPTH; i++) do_req(PUSH, 32'hC000_0000 + 32'(i), 1'b0);
    do_req(PUSH, 32'hFFFFFFFF, 1'b0);
    do_req(POP, '0, 1'b0);
    do_req(PUSH, 32'h0BAD_F00D, 1'b1);

    // Randomized traffic (push-weighted so the full boundary is revisited)
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] op;
      r  = int'($urandom_range(0, 9));
      op = (r < 4) ? PUSH : (r < 7) ? POP : (r < 9) ? PEEK : NOP;
      do_req(op, $urandom, ($urandom_range(0, 7) == 0));
    end

    // Reset during the READ cycle of a pop: no response, scrub re-runs
    do_req(PUSH, 32'h5555AAAA, 1'b0);
    wait_ready(ok);
    if (ok) begin
      req_valid = 1'b1;
      req_op    = POP;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_op    = NOP;
      reset     = 1'b1;
      @(negedge clock);
      chk("midpop_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midpop_req_ready", 64'(req_ready), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      stk.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
      scrub_check();
    end

    // Scrub must have zeroed stale entries: a push then a peek still works,
    // and the pointer sequence is intact after the aborted pop.
    v = $urandom;
    do_req(PUSH, v, 1'b0);
    do_req(PEEK, '0, 1'b0);
    do_req(POP, '0, 1'b0);

    repeat (5) @(negedge clock);
    chk("pending_responses", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEPTH, 32, number of stack entries; power of two, minimum 4.
- WIDTH, 32, entry width in bits.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_op  in  2  request opcode: 00 NOP, 01 PUSH, 10 POP, 11 PEEK.
- req_data  in  WIDTH  push data.
- rsp_valid  out  1  single-cycle response strobe.
- rsp_data  out  WIDTH  pop/peek result.
- esp  out  32  stack pointer, zero-extended entry index.
- full  out  1  high when esp==0.
- empty  out  1  high when esp==DEPTH.
- overflow_err  out  1  sticky flag: push was attempted while full.
- underflow_err  out  1  sticky flag: pop or peek was attempted while empty.
- clear_err  in  1  clears both error flags.

REQ-003 There SHALL be one clock; reset SHALL be synchronous and active-high, with the ports named clock and reset.

Function
REQ-004 A request SHALL be accepted on a cycle when req_valid and req_ready are both high.
REQ-005 req_ready SHALL be high only in state IDLE with reset low.
REQ-006 FSM states SHALL be SCRUB, IDLE, WRITE, READ and RESP.
REQ-007 SCRUB SHALL write zero to entry scrub_cnt each cycle, with scrub_cnt running 0..DEPTH-1, then go to IDLE; SCRUB lasts exactly DEPTH cycles.
REQ-008 A NOP accepted in IDLE SHALL stay in IDLE with no side effects.
REQ-009 PUSH accepted while not full SHALL latch req_data and go to WRITE.
- WRITE stores the data to mem[esp-1] and sets esp to esp-1, then returns to IDLE.
- rsp_valid is not asserted for a push.
REQ-010 PUSH accepted while full SHALL perform no write, leave esp unchanged, set overflow_err, and stay in IDLE.
REQ-011 POP or PEEK accepted while not empty SHALL go to READ, which performs a synchronous read of mem[esp], then to RESP.
- In RESP: rsp_valid=1 for one cycle and rsp_data holds the read data.
- On POP only, esp is set to esp+1 in the RESP cycle.
- Latency is 2 cycles from acceptance to rsp_valid.
REQ-012 POP or PEEK accepted while empty SHALL go directly to RESP.
- rsp_data=0, esp unchanged, underflow_err set.
- Latency is 1 cycle.
REQ-013 rsp_data SHALL hold its last value outside RESP.
REQ-014 full and empty SHALL be combinational decodes of esp.
REQ-015 clear_err SHALL clear both error flags; a set event in the same cycle SHALL take priority over the clear.
REQ-016 esp SHALL never leave the range 0..DEPTH; no wrap-around is permitted.

Reset
REQ-017 While reset is high, the block SHALL drive:
- state=SCRUB, scrub_cnt=0, esp=DEPTH.
- rsp_valid=0, rsp_data=0.
- overflow_err=0, underflow_err=0, req_ready=0.
REQ-018 Reset asserted mid-operation SHALL abort any pending write or response: no rsp_valid, no esp change. The scrub SHALL restart on the first cycle after reset deasserts.
REQ-019 Memory contents SHALL be all-zero once SCRUB completes; no reset is applied to the array itself.

Structure
REQ-020 The shared package stack_ctrl_pkg SHALL hold:
- the opcode localparams (OP_NOP, OP_PUSH, OP_POP, OP_PEEK);
- the FSM state enum;
- the default DEPTH and WIDTH.
REQ-021 The storage SHALL be a single sub-module, stack_ram: DEPTH x WIDTH, one synchronous write port and one synchronous read port, one-cycle read latency.
REQ-022 The FSM, esp register and error flags SHALL reside in stack_controller.

Verification
REQ-023 Reset scrub: hold reset for 3 cycles, then release -> req_ready=0 for exactly 32 cycles, then 1; esp=32, empty=1, full=0.
REQ-024 Push/pop ordering: push 0xDEADBEEF, then push 0x12345678, then pop twice -> responses 0x12345678 then 0xDEADBEEF, each 2 cycles after acceptance; esp sequence 32, 31, 30, 31, 32.
REQ-025 Peek: push 0xA5A5A5A5, then peek -> rsp_data=0xA5A5A5A5 and esp stays 31; a following pop returns the same value and esp=32.
REQ-026 Full boundary: 32 pushes -> full=1 and esp=0; a 33rd push of 0xFFFFFFFF -> overflow_err=1, esp=0, and a subsequent pop returns the 32nd pushed value.
REQ-027 Empty boundary: pop on an empty stack -> rsp_valid 1 cycle after acceptance with rsp_data=0, underflow_err=1, esp=32; then clear_err=1 -> underflow_err=0 on the next cycle.
REQ-028 Reset mid-pop: accept a pop, then assert reset in the READ cycle -> no rsp_valid, esp=32, full scrub re-run.
